// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, idle line level and parity helper.
// Also intended for use by the receive stage.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Even parity when odd=0: returned bit makes the total count of ones even.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_stage_if.sv
// Byte handshake between the word-to-byte FIFO and the UART transmit stage.
// The FIFO side is the master; the transmit stage is the slave.
interface uart_tx_stage_if;
  logic       fifo_valid;
  logic       fifo_rd_en;
  logic [7:0] fifo_data;

  modport master (output fifo_valid, output fifo_data, input fifo_rd_en);
  modport slave  (input fifo_valid, input fifo_data, output fifo_rd_en);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == CNT_LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_tick = ~clear & (count == CNT_LAST);

endmodule

// File: rtl/uart_tx_stage.sv
// UART transmit stage: pops bytes from the FIFO and sends 8N1/8E1/8O1/8N2 frames, LSB first.
// tx is registered from the next-state value so the line changes exactly at state boundaries.
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  uart_tx_stage_if.slave         fifo,
  output logic                   tx,
  output logic                   busy,
  output logic                   byte_done
);

  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        byte_done_q;
  logic        frame_end;
  logic        rd_en;
  logic        baud_clear;
  logic        bit_tick;

  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      parity_q    <= 1'b0;
      tx_q        <= TX_IDLE_LEVEL;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
      byte_done_q <= frame_end;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    rd_en      = 1'b0;
    frame_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && fifo.fifo_valid) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d    = fifo.fifo_data;
        parity_d   = parity_bit(fifo.fifo_data, PARITY_ODD != 0);
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        state_d    = ST_START;
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_idx_q == STOP_LAST) begin
            frame_end = 1'b1;
            // enable is only consulted here and in IDLE, so a drop mid-frame lets it finish
            state_d   = (enable && fifo.fifo_valid) ? ST_FETCH : ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = TX_IDLE_LEVEL;
    endcase
  end

  assign fifo.fifo_rd_en = rd_en;
  assign tx              = tx_q;
  assign busy            = (state_q != ST_IDLE);
  assign byte_done       = byte_done_q;

endmodule

// File: tb/tb_uart_tx_stage.sv
// Three transmit stages (8N1, 8E2, 8O1) driven from FIFO models; a line decoder per lane
// checks every frame cycle-by-cycle against a frame built from the queued byte.
module tb_uart_tx_stage;

  localparam int CPB = 4;
  localparam logic [2:0] PE_V = 3'b110;
  localparam logic [2:0] PO_V = 3'b100;
  localparam logic [2:0] S2_V = 3'b010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  event go_reset;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int lane, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %0d expected %0d at cycle %0d", lane, name, act, exp, cyc);
    end
  endtask

  for (genvar L = 0; L < 3; L++) begin : g_lane
    localparam int LN = L;
    localparam int PE = int'(PE_V[L]);
    localparam int PO = int'(PO_V[L]);
    localparam int SB = S2_V[L] ? 2 : 1;
    localparam int FL = CPB * (10 + PE + SB - 1);

    uart_tx_stage_if bus ();
    logic       enable = 1'b0;
    logic       tx, busy, byte_done;
    logic [7:0] mem [0:255];
    logic [7:0] data_r = 8'h00;
    logic [7:0] exp_q [$];
    int   wr_ptr = 0, rd_ptr = 0;
    int   pops = 0, pop_cyc = -100, done_cnt = 0, frames = 0, dropped = 0;
    int   end_mark = -1000, last_gap = 0;
    logic rd_prev = 1'b0;
    bit   ready = 1'b0, done = 1'b0;

    assign bus.fifo_valid = (wr_ptr != rd_ptr);
    assign bus.fifo_data  = data_r;

    uart_tx_stage #(
      .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
    ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fifo(bus),
      .tx(tx), .busy(busy), .byte_done(byte_done)
    );

    // FIFO model: data appears the cycle after the pop request
    always @(posedge clk) begin
      if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
        data_r <= mem[rd_ptr % 256];
        rd_ptr <= rd_ptr + 1;
      end
    end

    always @(negedge clk) begin
      if (bus.fifo_rd_en) begin
        chk("pop_when_valid", LN, int'(bus.fifo_valid), 1);
        chk("rd_en_single_cycle", LN, int'(rd_prev), 0);
        pops = pops + 1;
        pop_cyc = cyc;
      end
      if (byte_done) done_cnt = done_cnt + 1;
      rd_prev = bus.fifo_rd_en;
    end

    task automatic push(input logic [7:0] b);
      mem[wr_ptr % 256] = b;
      exp_q.push_back(b);
      wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_frames(input int target);
      int n = 0;
      while (frames < target && n < 3000) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      chk("frames_sent", LN, frames, target);
    endtask

    task automatic wait_pops(input int target);
      int n = 0;
      while (pops < target && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("pops_seen", LN, pops, target);
    endtask

    initial begin : mon
      logic [7:0] eb, dec;
      logic       fb [$];
      int         s, mism;
      bit         ab;
      forever begin
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
          s = cyc;
          chk("start_latency", LN, s - pop_cyc, 2);
          chk("busy_in_frame", LN, int'(busy), 1);
          last_gap = s - end_mark;
          if (exp_q.size() == 0) begin
            chk("expected_available", LN, 0, 1);
            eb = 8'h00;
          end else begin
            eb = exp_q.pop_front();
          end
          fb.delete();
          fb.push_back(1'b0);
          for (int i = 0; i < 8; i++) fb.push_back(eb[i]);
          if (PE != 0) fb.push_back(1'(($countones(eb) + PO) % 2));
          for (int i = 0; i < SB; i++) fb.push_back(1'b1);
          mism = 0;
          dec = 8'h00;
          ab = 1'b0;
          for (int k = 0; k < FL; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) begin
              ab = 1'b1;
              break;
            end
            if (tx !== fb[k / CPB]) mism++;
            if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= 8) dec[k / CPB - 1] = tx;
          end
          if (ab) begin
            dropped++;
          end else begin
            chk("frame_shape", LN, mism, 0);
            chk("data_byte", LN, int'(dec), int'(eb));
            @(negedge clk);
            chk("byte_done_after_stop", LN, int'(byte_done), 1);
            chk("line_high_after_frame", LN, int'(tx), 1);
            end_mark = cyc;
            frames++;
          end
        end
      end
    end

    initial begin : stim
      int f0, p0, nbytes;
      repeat (2) @(negedge clk);
      chk("reset_tx", LN, int'(tx), 1);
      chk("reset_busy", LN, int'(busy), 0);
      chk("reset_byte_done", LN, int'(byte_done), 0);
      chk("reset_rd_en", LN, int'(bus.fifo_rd_en), 0);
      @(posedge rst_n);
      @(negedge clk);

      enable = 1'b1;
      push(8'hA5);
      wait_frames(1);
      chk("single_pop", LN, pops, 1);
      chk("single_byte_done", LN, done_cnt, 1);
      repeat (5) @(negedge clk);
      chk("idle_busy", LN, int'(busy), 0);
      chk("idle_tx", LN, int'(tx), 1);

      push(8'h00);
      push(8'hFF);
      wait_frames(3);
      chk("back_to_back_gap", LN, last_gap, 2);
      chk("back_to_back_pops", LN, pops, 3);
      chk("back_to_back_done", LN, done_cnt, 3);

      push(8'h07);
      wait_frames(4);

      p0 = pops;
      push(8'h34);
      push(8'h12);
      wait_pops(p0 + 2);
      @(negedge clk);
      chk("fifo_empty_after_word", LN, int'(bus.fifo_valid), 0);
      wait_frames(6);

      nbytes = 24;
      for (int i = 0; i < nbytes; i++) begin
        int gap = $urandom_range(0, 30);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          enable = ($urandom_range(0, 3) != 0);
        end
        push(8'($urandom_range(0, 255)));
      end
      @(negedge clk);
      enable = 1'b1;
      wait_frames(6 + nbytes);

      f0 = frames;
      p0 = pops;
      push(8'h5A);
      push(8'hC3);
      wait_pops(p0 + 1);
      repeat (2 + CPB + 3 * CPB) @(negedge clk);
      enable = 1'b0;
      wait_frames(f0 + 1);
      repeat (20) @(negedge clk);
      chk("no_pop_after_enable_drop", LN, pops, p0 + 1);
      chk("held_line_high", LN, int'(tx), 1);
      chk("held_not_busy", LN, int'(busy), 0);
      enable = 1'b1;
      wait_frames(f0 + 2);

      p0 = pops;
      ready = 1'b1;
      @(go_reset);
      @(negedge clk);
      push(8'h3C);
      @(negedge rst_n);
      #1;
      chk("reset_mid_tx", LN, int'(tx), 1);
      chk("reset_mid_busy", LN, int'(busy), 0);
      chk("reset_mid_rd_en", LN, int'(bus.fifo_rd_en), 0);
      chk("popped_before_reset", LN, pops, p0 + 1);
      @(posedge rst_n);
      repeat (6) @(negedge clk);
      chk("no_pop_when_empty", LN, pops, p0 + 1);
      enable = 1'b0;
      push(8'h81);
      repeat (10) @(negedge clk);
      chk("no_pop_when_disabled", LN, pops, p0 + 1);
      f0 = frames;
      enable = 1'b1;
      wait_frames(f0 + 1);

      chk("total_pops", LN, pops, wr_ptr);
      chk("total_byte_done", LN, done_cnt, frames);
      chk("dropped_frames", LN, dropped, 1);
      chk("queue_drained", LN, exp_q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin : main
    int n;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!(g_lane[0].ready && g_lane[1].ready && g_lane[2].ready) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("lanes_ready", 0, int'(g_lane[0].ready && g_lane[1].ready && g_lane[2].ready), 1);
    ->go_reset;
    // lanes push one cycle later; bit 4 of that frame starts 24 cycles after the trigger
    repeat (25) @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!(g_lane[0].done && g_lane[1].done && g_lane[2].done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("lanes_done", 0, int'(g_lane[0].done && g_lane[1].done && g_lane[2].done), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
